// File: rtl/dma_arb_pkg.sv
// rtl/dma_arb_pkg.sv - shared state, register-select and config-select codes for the DMA channel arbiter
// Purpose: common definitions imported by dma_channel_arbiter and its picker.
// Contents: arbiter FSM state enum, DMAC REGSEL codes, shadow-register CFG_SEL codes.
package dma_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PROG0 = 3'd1,
    ST_PROG1 = 3'd2,
    ST_PROG2 = 3'd3,
    ST_XFER  = 3'd4,
    ST_DONE  = 3'd5
  } arb_state_e;

  // DMAC register select codes driven on REGSEL
  localparam logic [1:0] REGSEL_MODE  = 2'd0;
  localparam logic [1:0] REGSEL_COUNT = 2'd1;
  localparam logic [1:0] REGSEL_ADDR  = 2'd2;

  // Shadow register select codes accepted on CFG_SEL
  localparam logic [1:0] CFG_SEL_MODE   = 2'd0;
  localparam logic [1:0] CFG_SEL_COUNT  = 2'd1;
  localparam logic [1:0] CFG_SEL_ADDR   = 2'd2;
  localparam logic [1:0] CFG_SEL_ENABLE = 2'd3;

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational rotating-priority picker
// Purpose: choose the first eligible channel strictly after the last-served one, wrapping modulo NCH.
// Ports:
//   eligible  in   NCH  per-channel eligible vector
//   last      in   CW   last-served channel index
//   found     out  1    at least one channel is eligible
//   index     out  CW   winning channel index (0 when nothing is eligible)
module rr_priority_picker #(
  parameter int NCH = 4,
  parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] eligible,
  input  logic [CW-1:0]  last,
  output logic           found,
  output logic [CW-1:0]  index
);

  logic          hi_found;
  logic          lo_found;
  logic [CW-1:0] hi_idx;
  logic [CW-1:0] lo_idx;

  // Scan downwards so the lowest matching index is the one left standing.
  // hi_* tracks the lowest eligible index above last; lo_* the lowest overall,
  // which is the wrap-around winner when nothing above last is eligible.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        lo_found = 1'b1;
        lo_idx   = CW'(i);
        if (i > int'(last)) begin
          hi_found = 1'b1;
          hi_idx   = CW'(i);
        end
      end
    end
  end

  assign found = lo_found;
  assign index = hi_found ? hi_idx : lo_idx;

endmodule

// File: rtl/dma_channel_arbiter.sv
// rtl/dma_channel_arbiter.sv - rotating-priority front end sharing one DMAC between NCH requesters
// Purpose: arbitrate peripheral requests, program the DMAC mode/count/address for the winner,
//          then pass DREQ/DACK/EOP between the DMAC and the owning channel.
// Ports:
//   CLK, RST                       clock, synchronous active-high reset
//   CH_DREQ / CH_DACK / CH_EOP     per-channel request in, acknowledge and end pulse out
//   CFG_WE/CFG_CH/CFG_SEL/CFG_DATA shadow register write port
//   REGW / REGSEL / Setup          DMAC register write port
//   DREQ / DACK / EOP              DMAC handshake
//   GRANT_VLD / GRANT_CH           current owner of the DMAC
module dma_channel_arbiter
  import dma_arb_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = 2
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [NCH-1:0] CH_DREQ,
  output logic [NCH-1:0] CH_DACK,
  output logic [NCH-1:0] CH_EOP,
  input  logic           CFG_WE,
  input  logic [CW-1:0]  CFG_CH,
  input  logic [1:0]     CFG_SEL,
  input  logic [15:0]    CFG_DATA,
  output logic           REGW,
  output logic [1:0]     REGSEL,
  output logic [15:0]    Setup,
  output logic           DREQ,
  input  logic           DACK,
  input  logic           EOP,
  output logic           GRANT_VLD,
  output logic [CW-1:0]  GRANT_CH
);

  arb_state_e state_q, state_d;

  logic [15:0]    mode_q  [NCH];
  logic [15:0]    count_q [NCH];
  logic [15:0]    addr_q  [NCH];
  logic [NCH-1:0] en_q;
  logic [CW-1:0]  last_q;

  logic           regw_q, regw_d;
  logic [1:0]     regsel_q, regsel_d;
  logic [15:0]    setup_q, setup_d;
  logic           dreq_q, dreq_d;
  logic [NCH-1:0] ch_dack_q, ch_dack_d;
  logic [NCH-1:0] ch_eop_q, ch_eop_d;
  logic           grant_vld_q, grant_vld_d;
  logic [CW-1:0]  grant_ch_q, grant_ch_d;

  logic           pick_found;
  logic [CW-1:0]  pick_idx;
  logic [CW-1:0]  sel_ch;
  logic           cfg_ok;

  rr_priority_picker #(
    .NCH (NCH),
    .CW  (CW)
  ) u_picker (
    .eligible (CH_DREQ & en_q),
    .last     (last_q),
    .found    (pick_found),
    .index    (pick_idx)
  );

  // In IDLE the owner is not latched yet, so the picker result stands in for it.
  assign sel_ch = (state_q == ST_IDLE) ? pick_idx : grant_ch_q;

  // The owning channel's shadows are frozen while it holds the DMAC.
  assign cfg_ok = CFG_WE && !(grant_vld_q && (CFG_CH == grant_ch_q));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pick_found) state_d = (count_q[pick_idx] == 16'd0) ? ST_DONE : ST_PROG0;
      ST_PROG0: state_d = ST_PROG1;
      ST_PROG1: state_d = ST_PROG2;
      ST_PROG2: state_d = ST_XFER;
      ST_XFER:  if (EOP) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    regw_d      = 1'b0;
    regsel_d    = 2'd0;
    setup_d     = 16'd0;
    dreq_d      = 1'b0;
    ch_dack_d   = '0;
    ch_eop_d    = '0;
    grant_vld_d = 1'b0;
    grant_ch_d  = grant_ch_q;
    case (state_d)
      ST_PROG0: begin
        regw_d      = 1'b1;
        regsel_d    = REGSEL_MODE;
        setup_d     = mode_q[sel_ch];
        grant_vld_d = 1'b1;
        grant_ch_d  = sel_ch;
      end
      ST_PROG1: begin
        regw_d      = 1'b1;
        regsel_d    = REGSEL_COUNT;
        setup_d     = count_q[sel_ch];
        grant_vld_d = 1'b1;
      end
      ST_PROG2: begin
        regw_d      = 1'b1;
        regsel_d    = REGSEL_ADDR;
        setup_d     = addr_q[sel_ch];
        grant_vld_d = 1'b1;
      end
      ST_XFER: begin
        // Live request passes through so peripheral pauses reach the DMAC.
        dreq_d            = CH_DREQ[sel_ch];
        ch_dack_d[sel_ch] = DACK;
        grant_vld_d       = 1'b1;
      end
      ST_DONE: begin
        ch_eop_d[sel_ch] = 1'b1;
        grant_ch_d       = sel_ch;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      last_q      <= CW'(NCH - 1);
      en_q        <= '0;
      regw_q      <= 1'b0;
      regsel_q    <= 2'd0;
      setup_q     <= 16'd0;
      dreq_q      <= 1'b0;
      ch_dack_q   <= '0;
      ch_eop_q    <= '0;
      grant_vld_q <= 1'b0;
      grant_ch_q  <= '0;
      for (int i = 0; i < NCH; i++) begin
        mode_q[i]  <= 16'd0;
        count_q[i] <= 16'd0;
        addr_q[i]  <= 16'd0;
      end
    end else begin
      state_q     <= state_d;
      regw_q      <= regw_d;
      regsel_q    <= regsel_d;
      setup_q     <= setup_d;
      dreq_q      <= dreq_d;
      ch_dack_q   <= ch_dack_d;
      ch_eop_q    <= ch_eop_d;
      grant_vld_q <= grant_vld_d;
      grant_ch_q  <= grant_ch_d;
      if (state_d == ST_DONE) last_q <= sel_ch;
      if (cfg_ok) begin
        case (CFG_SEL)
          CFG_SEL_MODE:   mode_q[CFG_CH]  <= CFG_DATA;
          CFG_SEL_COUNT:  count_q[CFG_CH] <= CFG_DATA;
          CFG_SEL_ADDR:   addr_q[CFG_CH]  <= CFG_DATA;
          CFG_SEL_ENABLE: en_q[CFG_CH]    <= CFG_DATA[0];
          default: ;
        endcase
      end
    end
  end

  assign REGW      = regw_q;
  assign REGSEL    = regsel_q;
  assign Setup     = setup_q;
  assign DREQ      = dreq_q;
  assign CH_DACK   = ch_dack_q;
  assign CH_EOP    = ch_eop_q;
  assign GRANT_VLD = grant_vld_q;
  assign GRANT_CH  = grant_ch_q;

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// tb/tb_dma_channel_arbiter.sv - self-checking bench for dma_channel_arbiter
module tb_dma_channel_arbiter;

  localparam int NCH = 4;
  localparam int CW  = 2;

  logic           CLK = 1'b0;
  logic           RST;
  logic [NCH-1:0] CH_DREQ;
  logic [NCH-1:0] CH_DACK;
  logic [NCH-1:0] CH_EOP;
  logic           CFG_WE;
  logic [CW-1:0]  CFG_CH;
  logic [1:0]     CFG_SEL;
  logic [15:0]    CFG_DATA;
  logic           REGW;
  logic [1:0]     REGSEL;
  logic [15:0]    Setup;
  logic           DREQ;
  logic           DACK;
  logic           EOP;
  logic           GRANT_VLD;
  logic [CW-1:0]  GRANT_CH;

  dma_channel_arbiter #(.NCH(NCH), .CW(CW)) dut (
    .CLK(CLK), .RST(RST), .CH_DREQ(CH_DREQ), .CH_DACK(CH_DACK), .CH_EOP(CH_EOP),
    .CFG_WE(CFG_WE), .CFG_CH(CFG_CH), .CFG_SEL(CFG_SEL), .CFG_DATA(CFG_DATA),
    .REGW(REGW), .REGSEL(REGSEL), .Setup(Setup), .DREQ(DREQ), .DACK(DACK), .EOP(EOP),
    .GRANT_VLD(GRANT_VLD), .GRANT_CH(GRANT_CH)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A grant is a list of pending register writes followed by a transfer that
  // lasts until EOP; the finishing pulse is followed by one idle cycle.
  logic [15:0] sh_mode [NCH];
  logic [15:0] sh_count[NCH];
  logic [15:0] sh_addr [NCH];
  bit          sh_en   [NCH];
  int          m_last, m_owner, p_gch, m_win, m_sel;
  bit          m_busy, m_fin, m_xfer, m_live, p_gv;
  int          regq[$];
  logic           m_regw, m_dreq, m_gv;
  logic [1:0]     m_regsel;
  logic [15:0]    m_setup;
  logic [NCH-1:0] m_dack, m_eop;
  logic [CW-1:0]  m_gch;

  initial m_live = 1'b0;

  always @(posedge CLK) begin
    p_gv  = m_gv;
    p_gch = int'(m_gch);
    if (RST) begin
      for (int i = 0; i < NCH; i++) begin
        sh_mode[i] = 0; sh_count[i] = 0; sh_addr[i] = 0; sh_en[i] = 0;
      end
      m_last = NCH - 1; m_busy = 0; m_fin = 0; m_xfer = 0; regq.delete();
      m_regw = 0; m_regsel = 0; m_setup = 0; m_dreq = 0; m_dack = 0; m_eop = 0;
      m_gv = 0; m_gch = 0; m_live = 1;
    end else begin
      m_regw = 0; m_regsel = 0; m_setup = 0; m_dreq = 0; m_dack = 0; m_eop = 0;
      if (m_fin) begin
        m_fin = 0;
        m_gv  = 0;
      end else if (!m_busy) begin
        m_win = -1;
        for (int k = 1; k <= NCH; k++) begin
          int c;
          c = (m_last + k) % NCH;
          if (m_win < 0 && CH_DREQ[c] && sh_en[c]) m_win = c;
        end
        if (m_win >= 0) begin
          m_gch = CW'(m_win);
          if (sh_count[m_win] == 0) begin
            m_eop[m_win] = 1; m_gv = 0; m_last = m_win; m_fin = 1;
          end else begin
            m_busy = 1; m_owner = m_win;
            regq = '{0, 1, 2};
          end
        end
      end
      if (m_busy && regq.size() > 0) begin
        m_sel = regq.pop_front();
        m_regw = 1; m_regsel = 2'(m_sel); m_gv = 1;
        m_setup = (m_sel == 0) ? sh_mode[m_owner] : (m_sel == 1) ? sh_count[m_owner] : sh_addr[m_owner];
      end else if (m_busy && m_xfer && EOP) begin
        m_eop[m_owner] = 1; m_gv = 0; m_last = m_owner; m_busy = 0; m_xfer = 0; m_fin = 1;
      end else if (m_busy && !(m_xfer == 0 && m_regw)) begin
        m_xfer = 1; m_dreq = CH_DREQ[m_owner]; m_dack[m_owner] = DACK; m_gv = 1;
      end
      if (CFG_WE && !(p_gv && int'(CFG_CH) == p_gch)) begin
        case (CFG_SEL)
          2'd0: sh_mode[CFG_CH]  = CFG_DATA;
          2'd1: sh_count[CFG_CH] = CFG_DATA;
          2'd2: sh_addr[CFG_CH]  = CFG_DATA;
          default: sh_en[CFG_CH] = CFG_DATA[0];
        endcase
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(posedge CLK) begin
    #1;
    if (m_live) begin
      n_checks++;
      if (REGW !== m_regw || REGSEL !== m_regsel || Setup !== m_setup || DREQ !== m_dreq ||
          CH_DACK !== m_dack || CH_EOP !== m_eop || GRANT_VLD !== m_gv || GRANT_CH !== m_gch) begin
        n_fail++;
        $display("FAIL model_cycle t=%0t got/exp regw=%0b/%0b regsel=%0d/%0d setup=%h/%h dreq=%0b/%0b dack=%b/%b eop=%b/%b gv=%0b/%0b gch=%0d/%0d",
                 $time, REGW, m_regw, REGSEL, m_regsel, Setup, m_setup, DREQ, m_dreq,
                 CH_DACK, m_dack, CH_EOP, m_eop, GRANT_VLD, m_gv, GRANT_CH, m_gch);
      end
    end
  end

  // Grant-order recorder for the round-robin test.
  bit rec_en = 0;
  bit gv_prev = 0;
  int grant_seq[$];
  always @(posedge CLK) begin
    #1;
    if (rec_en && GRANT_VLD && !gv_prev) grant_seq.push_back(int'(GRANT_CH));
    gv_prev = GRANT_VLD;
  end

  // ---------------- stimulus helpers ----------------
  task automatic cfg(input int ch, input int sel, input logic [15:0] data);
    CFG_WE = 1; CFG_CH = CW'(ch); CFG_SEL = 2'(sel); CFG_DATA = data;
    @(negedge CLK);
    CFG_WE = 0;
  endtask

  task automatic do_reset();
    RST = 1;
    @(negedge CLK);
    @(negedge CLK);
    RST = 0;
  endtask

  task automatic wait_gv(input string name);
    int i;
    i = 0;
    while (!GRANT_VLD && i < 50) begin
      @(posedge CLK); #1;
      i++;
    end
    if (!GRANT_VLD) chk({name, "_grant_timeout"}, 32'(GRANT_VLD), 32'd1);
  endtask

  task automatic prog_check(input int ch, input logic [15:0] addr, input string name);
    @(negedge CLK);
    CH_DREQ = 4'(1 << ch);
    wait_gv(name);
    chk({name, "_gch"}, 32'(GRANT_CH), 32'(ch));
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk({name, "_regsel"}, 32'(REGSEL), 32'd2);
    chk({name, "_setup"}, 32'(Setup), 32'(addr));
    @(posedge CLK);
    @(negedge CLK); EOP = 1;
    @(negedge CLK); EOP = 0; CH_DREQ = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int nregw, neop3, ngv, nbad;
    RST = 1; CH_DREQ = 0; CFG_WE = 0; CFG_CH = 0; CFG_SEL = 0; CFG_DATA = 0; DACK = 0; EOP = 0;

    // Reset: enable write during reset is not retained
    @(negedge CLK);
    CFG_WE = 1; CFG_CH = 0; CFG_SEL = 3; CFG_DATA = 16'h0001;
    @(negedge CLK);
    CFG_WE = 0; RST = 0;
    chk("rst_gv", 32'(GRANT_VLD), 0);
    chk("rst_regw", 32'(REGW), 0);
    chk("rst_dack", 32'(CH_DACK), 0);
    chk("rst_eop", 32'(CH_EOP), 0);
    chk("rst_dreq", 32'(DREQ), 0);
    CH_DREQ = 4'b0001;
    repeat (3) begin
      @(negedge CLK);
      chk("rst_en_not_kept", 32'(GRANT_VLD), 0);
    end
    CH_DREQ = 0;

    // Single channel program
    cfg(1, 0, 16'h0092); cfg(1, 1, 16'h0003); cfg(1, 2, 16'h0001); cfg(1, 3, 16'h0001);
    CH_DREQ = 4'b0010;
    @(posedge CLK); #1;
    chk("p0_regw", 32'(REGW), 1); chk("p0_regsel", 32'(REGSEL), 0); chk("p0_setup", 32'(Setup), 32'h0092);
    chk("p0_gv", 32'(GRANT_VLD), 1); chk("p0_gch", 32'(GRANT_CH), 1);
    @(posedge CLK); #1;
    chk("p1_regsel", 32'(REGSEL), 1); chk("p1_setup", 32'(Setup), 32'h0003);
    @(posedge CLK); #1;
    chk("p2_regsel", 32'(REGSEL), 2); chk("p2_setup", 32'(Setup), 32'h0001);
    @(posedge CLK); #1;
    chk("x_regw", 32'(REGW), 0); chk("x_dreq_n4", 32'(DREQ), 1);
    @(negedge CLK); DACK = 1;
    @(posedge CLK); #1;
    chk("x_dack1", 32'(CH_DACK), 32'b0010);
    @(negedge CLK); DACK = 0; EOP = 1;
    @(posedge CLK); #1;
    chk("done_eop1", 32'(CH_EOP), 32'b0010); chk("done_gv", 32'(GRANT_VLD), 0); chk("done_dreq", 32'(DREQ), 0);
    @(negedge CLK); EOP = 0; CH_DREQ = 0;
    @(posedge CLK); #1;
    chk("eop_one_cycle", 32'(CH_EOP), 0);

    // Round robin between ch0 and ch2 with all four lines requesting
    @(negedge CLK);
    do_reset();
    cfg(0, 1, 16'h0002); cfg(0, 3, 16'h0001);
    cfg(2, 1, 16'h0005); cfg(2, 3, 16'h0001);
    rec_en = 1;
    CH_DREQ = 4'b1111;
    for (int g = 0; g < 4; g++) begin
      wait_gv("rr");
      repeat (7) @(posedge CLK);
      @(negedge CLK); EOP = 1;
      @(negedge CLK); EOP = 0;
      if (g == 3) CH_DREQ = 0;
    end
    rec_en = 0;
    chk("rr_count", 32'(grant_seq.size()), 4);
    if (grant_seq.size() == 4) begin
      chk("rr_g0", 32'(grant_seq[0]), 0);
      chk("rr_g1", 32'(grant_seq[1]), 2);
      chk("rr_g2", 32'(grant_seq[2]), 0);
      chk("rr_g3", 32'(grant_seq[3]), 2);
    end

    // Zero count on ch3, disabled ch2
    cfg(2, 3, 16'h0000); cfg(3, 3, 16'h0001);
    CH_DREQ = 4'b1100;
    nregw = 0; neop3 = 0; ngv = 0; nbad = 0;
    repeat (4) begin
      @(posedge CLK); #1;
      if (REGW) nregw++;
      if (CH_EOP[3]) neop3++;
      if (GRANT_VLD) ngv++;
      if (CH_EOP[2] || CH_DACK[2]) nbad++;
    end
    chk("zc_regw", 32'(nregw), 0);
    chk("zc_eop3", 32'(neop3), 2);
    chk("zc_gv", 32'(ngv), 0);
    chk("zc_ch2", 32'(nbad), 0);
    @(negedge CLK); CH_DREQ = 4'b0100;
    ngv = 0;
    repeat (5) begin
      @(negedge CLK);
      if (GRANT_VLD) ngv++;
    end
    chk("dis_ch2", 32'(ngv), 0);
    CH_DREQ = 0;

    // Config collision during a ch1 transfer
    cfg(1, 0, 16'h0011); cfg(1, 1, 16'h0004); cfg(1, 2, 16'h0001); cfg(1, 3, 16'h0001);
    CH_DREQ = 4'b0010;
    wait_gv("col");
    chk("col_gch", 32'(GRANT_CH), 1);
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    cfg(1, 2, 16'hBEEF);
    cfg(0, 2, 16'h1234);
    EOP = 1;
    @(negedge CLK); EOP = 0; CH_DREQ = 0;
    prog_check(1, 16'h0001, "col_ch1");
    prog_check(0, 16'h1234, "col_ch0");

    // Mid-transfer reset
    @(negedge CLK);
    CH_DREQ = 4'b0001;
    wait_gv("mrst");
    repeat (3) @(posedge CLK);
    @(negedge CLK); DACK = 1;
    @(negedge CLK);
    chk("mrst_dack_before", 32'(CH_DACK), 32'b0001);
    RST = 1;
    @(posedge CLK); #1;
    chk("mrst_dreq", 32'(DREQ), 0);
    chk("mrst_dack", 32'(CH_DACK), 0);
    chk("mrst_gv", 32'(GRANT_VLD), 0);
    @(negedge CLK); RST = 0; DACK = 0; CH_DREQ = 0;
    cfg(1, 1, 16'h0001); cfg(1, 3, 16'h0001);
    cfg(0, 1, 16'h0001); cfg(0, 3, 16'h0001);
    CH_DREQ = 4'b0011;
    wait_gv("mrst2");
    chk("mrst_first_ch0", 32'(GRANT_CH), 0);
    repeat (3) @(posedge CLK);
    @(negedge CLK); EOP = 1;
    @(negedge CLK); EOP = 0; CH_DREQ = 0;
    repeat (4) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_channel_arbiter.md
Name: dma_channel_arbiter

Overview:
Multi-channel front end for the single DMAC engine. It shares one DMAC between NCH peripheral requesters using rotating priority. For each granted channel it programs the DMAC's mode, count and address registers over REGW/REGSEL/Setup, arms the DMAC via DREQ, then routes DACK and EOP back to the winning channel. It sits between peripheral DREQ lines and the DMAC's register and handshake ports.

Parameters:
NCH, 4, number of requesting channels (2..8)
CW, 2, channel index width, equal to clog2(NCH)

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  synchronous, active-high reset
CH_DREQ  in  NCH  per-channel DMA request, level
CH_DACK  out  NCH  per-channel acknowledge, one-hot or zero
CH_EOP  out  NCH  per-channel end-of-transfer pulse, one cycle
CFG_WE  in  1  shadow-register write strobe
CFG_CH  in  CW  channel addressed by the write
CFG_SEL  in  2  0=mode, 1=count, 2=address, 3=enable (bit0)
CFG_DATA  in  16  write data
REGW  out  1  DMAC register write enable
REGSEL  out  2  DMAC register select
Setup  out  16  DMAC register write data
DREQ  out  1  request to DMAC
DACK  in  1  acknowledge from DMAC
EOP  in  1  end-of-process from DMAC
GRANT_VLD  out  1  a channel currently owns the DMAC
GRANT_CH  out  CW  owning channel index

Behaviour:
- Interface: one clock CLK; reset RST is synchronous and active-high.
- Reset: all outputs 0; state IDLE; shadow mode/count/address/enable cleared; last-served pointer = NCH-1, so channel 0 has top priority first.
- Shadow registers: CFG_WE writes CFG_DATA to shadow[CFG_CH][CFG_SEL] at the clock edge.
  - The write is dropped if GRANT_VLD=1 and CFG_CH=GRANT_CH.
  - Writes to other channels always succeed, including in the same cycle as grant or EOP.
- Eligible channel: CH_DREQ[i]=1 and enable[i]=1.
- FSM states: IDLE, PROG0, PROG1, PROG2, XFER, DONE. All outputs are registered.
- IDLE: if any channel is eligible, pick the first eligible index after the last-served pointer, modulo NCH.
  - Latch it into GRANT_CH and set GRANT_VLD=1.
  - If shadow count of the winner = 0, go to DONE. Otherwise go to PROG0.
- PROG0/1/2: one cycle each, with REGW=1, REGSEL=0/1/2 and Setup = shadow mode/count/address of the winner. PROG2 goes to XFER.
- XFER: REGW=0; DREQ = CH_DREQ[GRANT_CH] (follows the live request, so cycle-steal pauses pass through); CH_DACK[GRANT_CH] = DACK, other bits 0.
  - EOP=1 goes to DONE.
  - EOP during PROG states is ignored.
- DONE: one cycle. DREQ=0, CH_DACK=0, CH_EOP[GRANT_CH]=1, last-served pointer = GRANT_CH, GRANT_VLD=0; return to IDLE.
- Latency: request sampled in IDLE at cycle n gives REGW high at n+1..n+3, DREQ at n+4 at the earliest. Minimum arbitration gap between two grants is 1 IDLE cycle.
- Disabling the active channel (enable write) is dropped per the rule above; the transfer completes.
- CH_DREQ[GRANT_CH] deasserting in PROG states does not abort; programming completes and DREQ stays 0 in XFER until the request returns or EOP arrives.
- RST at any cycle, including mid-PROG or mid-XFER, returns to reset values on the next edge. The DMAC is reset separately by the same RST.

Decomposition:
- Package dma_arb_pkg holds:
  - state enum;
  - REGSEL codes: MODE=0, COUNT=1, ADDR=2;
  - CFG_SEL codes, including ENABLE=3.
- One sub-module rr_priority_picker: combinational. Inputs are an eligible vector and the last-served pointer; outputs are found and index. Parameterised by NCH.

Test Plan:
- Reset check: hold RST for 2 cycles -> all outputs 0, GRANT_VLD=0; a CFG write of enable during reset is not retained.
- Single channel program: ch1 shadows mode=0x0092, count=0x0003, address=0x0001, enable=1; raise CH_DREQ[1] -> REGSEL 0,1,2 with Setup 0x0092, 0x0003, 0x0001 on consecutive cycles; DREQ=1 four cycles after sampling; DACK mirrored on CH_DACK[1]; EOP produces a one-cycle CH_EOP[1] pulse, then GRANT_VLD=0.
- Round-robin: ch0 and ch2 enabled, both requesting continuously, EOP returned after 5 cycles each -> grants in order 0, 2, 0, 2; ch1 and ch3 never granted.
- Zero count and disabled channel: ch3 count=0 -> DONE with no REGW pulses, CH_EOP[3] pulse; ch2 enable=0 with CH_DREQ[2]=1 -> never granted.
- Config collision: during a ch1 XFER, write ch1 address=0xBEEF and ch0 address=0x1234 -> ch1 shadow unchanged; ch0 address reads out as Setup=0x1234 on its next PROG2.
- Mid-transfer reset: assert RST in XFER -> next cycle DREQ=0, CH_DACK=0, GRANT_VLD=0; after release, ch0 wins first if requesting.
